ristretto_imem_ctrl: RTL and testbench

Instruction-memory controller that sits directly upstream of the fetch stage. It terminates the fetch stage's instruction-memory port: request, ready, valid, read data and address. It drives a synchronous single-port SRAM with a fixed read latency and returns one response per accepted request. It detects misaligned and out-of-range fetches and discards in-flight responses when a control or trap hazard flushes the front end.

---
 rtl/ristretto_imem_ctrl.sv | 86 ++++++++
 tb/tb_ristretto_imem_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_imem_ctrl.sv
// Instruction-memory controller between the fetch stage and a fixed-latency single-port SRAM.
// Tracks in-flight reads, flags misaligned/out-of-range fetches and squashes responses on flush.
module ristretto_imem_ctrl #(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MemDepth       = 1024,
    parameter int Latency        = 1,
    parameter int MaxOutstanding = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        imem_req_i,
    input  logic [AddrWidth-1:0]        imem_addr_i,
    input  logic                        imem_flush_i,
    output logic                        imem_ready_o,
    output logic                        imem_valid_o,
    output logic [DataWidth-1:0]        imem_rdata_o,
    output logic                        imem_err_o,
    output logic [AddrWidth-1:0]        err_addr_o,
    output logic                        busy_o,
    output logic                        sram_en_o,
    output logic [$clog2(MemDepth)-1:0] sram_addr_o,
    input  logic [DataWidth-1:0]        sram_rdata_i
);

    localparam int SramAw = $clog2(MemDepth);
    localparam int CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0]      MaxCnt     = CntW'(MaxOutstanding);
    localparam logic [AddrWidth-3:0] DepthWords = (AddrWidth-2)'(MemDepth);

    logic [Latency-1:0] vld_p;
    logic [Latency-1:0] err_p;
    logic [Latency-1:0] drop_p;
    logic [CntW-1:0]    cnt;
    logic               retire;
    logic               accept;
    logic               fault;
    logic               resp_drop;

    // A slot retiring this cycle may be reused immediately.
    assign retire       = vld_p[Latency-1];
    assign imem_ready_o = ~imem_flush_i & ((cnt < MaxCnt) | retire);
    assign accept       = imem_req_i & imem_ready_o;

    assign fault       = (imem_addr_i[1:0] != 2'b00) |
                         (imem_addr_i[AddrWidth-1:2] >= DepthWords);
    assign sram_en_o   = accept & ~fault;
    assign sram_addr_o = sram_en_o ? imem_addr_i[SramAw+1:2] : '0;

    // A flush in the retiring cycle squashes that response as well.
    assign resp_drop    = drop_p[Latency-1] | imem_flush_i;
    assign imem_valid_o = retire & ~resp_drop;
    assign imem_err_o   = imem_valid_o & err_p[Latency-1];
    assign imem_rdata_o = (imem_valid_o & ~err_p[Latency-1]) ? sram_rdata_i : '0;
    assign busy_o       = (cnt != '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p      <= '0;
            err_p      <= '0;
            drop_p     <= '0;
            cnt        <= '0;
            err_addr_o <= '0;
        end else begin
            // stage 0: capture the accepted request
            vld_p[0]  <= accept;
            err_p[0]  <= accept & fault;
            drop_p[0] <= 1'b0;
            // stages 1..Latency-1: shift, marking live entries dropped on flush
            for (int k = 1; k < Latency; k++) begin
                vld_p[k]  <= vld_p[k-1];
                err_p[k]  <= err_p[k-1];
                drop_p[k] <= drop_p[k-1] | (imem_flush_i & vld_p[k-1]);
            end
            if (accept & fault) begin
                err_addr_o <= imem_addr_i;
            end
            if (accept & ~retire) begin
                cnt <= cnt + 1'b1;
            end else if (~accept & retire) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ristretto_imem_ctrl.sv
// Randomized bench for ristretto_imem_ctrl against a queue-based model of in-flight fetches.
module tb_ristretto_imem_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 48;
    localparam int LAT   = 3;
    localparam int MAXO  = 2;
    localparam int SAW   = $clog2(DEPTH);

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic           imem_req_i;
    logic [AW-1:0]  imem_addr_i;
    logic           imem_flush_i;
    logic           imem_ready_o;
    logic           imem_valid_o;
    logic [DW-1:0]  imem_rdata_o;
    logic           imem_err_o;
    logic [AW-1:0]  err_addr_o;
    logic           busy_o;
    logic           sram_en_o;
    logic [SAW-1:0] sram_addr_o;
    logic [DW-1:0]  sram_rdata_i;

    always #5 clk_i = ~clk_i;

    ristretto_imem_ctrl #(
        .DataWidth(DW), .AddrWidth(AW), .MemDepth(DEPTH),
        .Latency(LAT), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_flush_i(imem_flush_i),
        .imem_ready_o(imem_ready_o), .imem_valid_o(imem_valid_o),
        .imem_rdata_o(imem_rdata_o), .imem_err_o(imem_err_o),
        .err_addr_o(err_addr_o), .busy_o(busy_o),
        .sram_en_o(sram_en_o), .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i)
    );

    // SRAM environment: fixed-latency read pipe
    logic [DW-1:0]  mem [DEPTH];
    logic           en_pipe [LAT];
    logic [SAW-1:0] a_pipe [LAT];

    always @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < LAT; k++) begin
                en_pipe[k] <= 1'b0;
                a_pipe[k]  <= '0;
            end
        end else begin
            en_pipe[0] <= sram_en_o;
            a_pipe[0]  <= sram_addr_o;
            for (int k = 1; k < LAT; k++) begin
                en_pipe[k] <= en_pipe[k-1];
                a_pipe[k]  <= a_pipe[k-1];
            end
        end
    end

    assign sram_rdata_i = en_pipe[LAT-1] ? mem[a_pipe[LAT-1]] : 32'hDEAD_BEEF;

    // Reference model: every accepted fetch is a queue entry due LAT cycles later
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        bit            fault;
        bit            drop;
    } ent_t;

    ent_t          q[$];
    int            cyc;
    int            n_chk;
    int            n_pass;
    logic [AW-1:0] m_err_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic bit is_fault(input logic [AW-1:0] a);
        longint unsigned ua;
        ua = longint'(a);
        return (ua % 4 != 0) || (ua / 4 >= DEPTH);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 9))
            6:       return AW'($urandom_range(0, DEPTH-1) * 4 + $urandom_range(1, 3));
            7:       return ($urandom_range(0, 1) != 0) ? AW'(DEPTH*4) : AW'((DEPTH-1)*4);
            8:       return AW'($urandom()) | 32'h8000_0000;
            9:       return AW'((DEPTH + $urandom_range(0, 15)) * 4);
            default: return AW'($urandom_range(0, DEPTH-1) * 4);
        endcase
    endfunction

    // One clock cycle: drive, check combinational outputs against the model, advance.
    task automatic step(input bit req, input logic [AW-1:0] addr, input bit flush);
        bit            ret_now, exp_ready, acc, f, ev, ee;
        logic [DW-1:0] er;
        imem_req_i   = req;
        imem_addr_i  = addr;
        imem_flush_i = flush;
        #2;
        ret_now   = (q.size() > 0) && (q[0].due == cyc);
        exp_ready = !flush && ((q.size() < MAXO) || ret_now);
        acc       = req && exp_ready;
        f         = is_fault(addr);
        ev        = ret_now && !q[0].drop && !flush;
        ee        = ev && q[0].fault;
        er        = (ev && !q[0].fault) ? mem[int'(q[0].addr / 4)] : '0;
        chk("ready", 64'(imem_ready_o), 64'(exp_ready));
        chk("valid", 64'(imem_valid_o), 64'(ev));
        chk("err",   64'(imem_err_o),   64'(ee));
        chk("rdata", 64'(imem_rdata_o), 64'(er));
        chk("busy",  64'(busy_o),       64'(q.size() != 0));
        chk("sram_en",   64'(sram_en_o),   64'(acc && !f));
        chk("sram_addr", 64'(sram_addr_o), (acc && !f) ? 64'(addr / 4) : 64'd0);
        chk("err_addr",  64'(err_addr_o),  64'(m_err_addr));
        if (flush) begin
            foreach (q[i]) q[i].drop = 1'b1;
        end
        if (ret_now) void'(q.pop_front());
        if (acc) begin
            q.push_back('{due: cyc + LAT, addr: addr, fault: f, drop: 1'b0});
            if (f) m_err_addr = addr;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},    64'(imem_valid_o), 64'd0);
        chk({tag, "_err"},      64'(imem_err_o),   64'd0);
        chk({tag, "_rdata"},    64'(imem_rdata_o), 64'd0);
        chk({tag, "_err_addr"}, 64'(err_addr_o),   64'd0);
        chk({tag, "_busy"},     64'(busy_o),       64'd0);
    endtask

    // Asynchronous reset asserted in the middle of a cycle with traffic in flight.
    task automatic mid_reset();
        imem_req_i   = 1'b0;
        imem_flush_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        chk("midrst_sram_en", 64'(sram_en_o),    64'd0);
        chk("midrst_ready",   64'(imem_ready_o), 64'd1);
        q.delete();
        m_err_addr = '0;
        repeat (2) @(posedge clk_i);
        #1;
        cyc += 2;
        rstn_i = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        m_err_addr = '0;
        rstn_i = 1'b0;
        imem_req_i = 1'b0;
        imem_addr_i = '0;
        imem_flush_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        mem[0] = 32'hA0;
        mem[1] = 32'hA1;
        mem[2] = 32'hA2;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("rst");
        chk("rst_sram_en", 64'(sram_en_o),    64'd0);
        chk("rst_ready",   64'(imem_ready_o), 64'd1);
        imem_flush_i = 1'b1;
        #1;
        chk("rst_ready_flush", 64'(imem_ready_o), 64'd0);
        imem_flush_i = 1'b0;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed: back-to-back fetches, faults, flush with request, flush mid-flight
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        step(1'b1, 32'h8, 1'b0);
        step(1'b1, 32'h6, 1'b0);
        step(1'b1, AW'(DEPTH*4), 1'b0);
        step(1'b1, 32'hC, 1'b1);
        step(1'b1, 32'hC, 1'b0);
        step(1'b1, 32'h10, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
        mid_reset();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1000 || i == 2000) mid_reset();
            step($urandom_range(0, 99) < 75, rand_addr(), $urandom_range(0, 99) < 8);
        end
        for (int i = 0; i < LAT + 2; i++) step(1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
